// File: rtl/snake_body_ctrl.sv
// Snake body controller: direction latch, step timing, segment shift register with
// wall/self collision detection and a sticky game-over.

module snake_seg #(
   parameter logic [5:0] RST_X = 6'd0,
   parameter logic [5:0] RST_Y = 6'd0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ld_i,
   input  logic [5:0] d_x_i,
   input  logic [5:0] d_y_i,
   input  logic [5:0] cmp_x_i,
   input  logic [5:0] cmp_y_i,
   output logic [5:0] x_o,
   output logic [5:0] y_o,
   output logic       hit_o
);
   logic [5:0] x_q, y_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q <= RST_X;
         y_q <= RST_Y;
      end else if (ld_i) begin
         x_q <= d_x_i;
         y_q <= d_y_i;
      end
   end

   assign x_o   = x_q;
   assign y_o   = y_q;
   assign hit_o = (x_q == cmp_x_i) && (y_q == cmp_y_i);
endmodule

module snake_body_ctrl #(
   parameter int          MAX_LEN  = 16,
   parameter int          INIT_LEN = 3,
   parameter int unsigned STEP_DIV = 12_500_000,
   parameter int          X_MAX    = 38,
   parameter int          Y_MAX    = 28
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   game_en_i,
   input  logic                   key_up_i,
   input  logic                   key_down_i,
   input  logic                   key_left_i,
   input  logic                   key_right_i,
   input  logic                   add_cube_i,
   input  logic                   died_i,
   output logic [5:0]             head_x_o,
   output logic [5:0]             head_y_o,
   output logic [6*MAX_LEN-1:0]   body_x_o,
   output logic [6*MAX_LEN-1:0]   body_y_o,
   output logic [4:0]             cube_num_o,
   output logic                   step_tick_o,
   output logic                   hit_wall_o,
   output logic                   hit_body_o,
   output logic                   game_over_o
);
   localparam int HEAD_X0 = 20;
   localparam int HEAD_Y0 = 15;

   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

   dir_e        dir_q, next_dir_q;
   logic [23:0] cnt_q;
   logic        step_pend_q, step_tick_q, grow_pend_q;
   logic [4:0]  cube_num_q;
   logic        hit_wall_q, hit_body_q, game_over_q;

   logic [MAX_LEN-1:0][5:0] seg_x, seg_y;
   logic [MAX_LEN-1:0]      seg_hit, seg_ld;

   function automatic dir_e rev_dir(input dir_e d);
      case (d)
         DIR_UP:   return DIR_DOWN;
         DIR_DOWN: return DIR_UP;
         DIR_LEFT: return DIR_RIGHT;
         default:  return DIR_LEFT;
      endcase
   endfunction

   // Highest-priority key this cycle; a reversal of the committed direction is dropped.
   dir_e key_dir;
   logic key_vld, key_ok;
   always_comb begin
      key_vld = 1'b1;
      key_dir = DIR_UP;
      if (key_up_i)         key_dir = DIR_UP;
      else if (key_down_i)  key_dir = DIR_DOWN;
      else if (key_left_i)  key_dir = DIR_LEFT;
      else if (key_right_i) key_dir = DIR_RIGHT;
      else                  key_vld = 1'b0;
   end
   assign key_ok = key_vld && (key_dir != rev_dir(dir_q));

   // Candidate head uses the pending direction, which becomes committed on the move.
   logic [5:0] nh_x, nh_y;
   always_comb begin
      nh_x = seg_x[0];
      nh_y = seg_y[0];
      case (next_dir_q)
         DIR_UP:    nh_y = seg_y[0] - 6'd1;
         DIR_DOWN:  nh_y = seg_y[0] + 6'd1;
         DIR_LEFT:  nh_x = seg_x[0] - 6'd1;
         default:   nh_x = seg_x[0] + 6'd1;
      endcase
   end

   logic wall;
   assign wall = (nh_x == 6'd0) || (nh_x > 6'(X_MAX)) ||
                 (nh_y == 6'd0) || (nh_y > 6'(Y_MAX));

   // Tail segment is excluded unless growing, since it vacates its cell on this move.
   logic [4:0] body_lim;
   logic       body_hit;
   assign body_lim = grow_pend_q ? (cube_num_q - 5'd1) : (cube_num_q - 5'd2);
   always_comb begin
      body_hit = 1'b0;
      for (int k = 1; k < MAX_LEN; k++)
         if (seg_hit[k] && (5'(k) <= body_lim)) body_hit = 1'b1;
   end

   logic       do_move, move_ok;
   logic [4:0] shift_lim;
   assign do_move   = step_pend_q && game_en_i && !game_over_q && !died_i;
   assign move_ok   = do_move && !wall && !body_hit;
   assign shift_lim = cube_num_q + {4'd0, grow_pend_q};

   for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
      localparam logic [5:0] RX = (i < INIT_LEN) ? 6'(HEAD_X0 - i) : 6'd0;
      localparam logic [5:0] RY = (i < INIT_LEN) ? 6'(HEAD_Y0)     : 6'd0;
      logic [5:0] dx, dy;
      if (i == 0) begin : g_head
         assign dx = nh_x;
         assign dy = nh_y;
      end else begin : g_body
         assign dx = seg_x[i-1];
         assign dy = seg_y[i-1];
      end
      assign seg_ld[i] = move_ok && (5'(i) < shift_lim);
      snake_seg #(.RST_X(RX), .RST_Y(RY)) u_seg (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .ld_i    (seg_ld[i]),
         .d_x_i   (dx),
         .d_y_i   (dy),
         .cmp_x_i (nh_x),
         .cmp_y_i (nh_y),
         .x_o     (seg_x[i]),
         .y_o     (seg_y[i]),
         .hit_o   (seg_hit[i])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dir_q       <= DIR_RIGHT;
         next_dir_q  <= DIR_RIGHT;
         cnt_q       <= '0;
         step_pend_q <= 1'b0;
         step_tick_q <= 1'b0;
         grow_pend_q <= 1'b0;
         cube_num_q  <= 5'(INIT_LEN);
         hit_wall_q  <= 1'b0;
         hit_body_q  <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         step_tick_q <= 1'b0;
         if (!game_over_q) begin
            if (key_ok)     next_dir_q  <= key_dir;
            if (add_cube_i) grow_pend_q <= 1'b1;
            if (game_en_i) begin
               if (cnt_q == 24'(STEP_DIV - 1)) begin
                  cnt_q       <= '0;
                  step_pend_q <= 1'b1;
               end else begin
                  cnt_q       <= cnt_q + 24'd1;
                  step_pend_q <= 1'b0;
               end
            end
            if (died_i) begin
               game_over_q <= 1'b1;
            end else if (do_move) begin
               if (wall) begin
                  hit_wall_q  <= 1'b1;
                  game_over_q <= 1'b1;
               end else if (body_hit) begin
                  hit_body_q  <= 1'b1;
                  game_over_q <= 1'b1;
               end else begin
                  step_tick_q <= 1'b1;
                  dir_q       <= next_dir_q;
                  // A pulse landing on the move edge is carried to the next move.
                  grow_pend_q <= add_cube_i;
                  if (grow_pend_q && (cube_num_q < 5'(MAX_LEN)))
                     cube_num_q <= cube_num_q + 5'd1;
               end
            end
         end
      end
   end

   assign head_x_o    = seg_x[0];
   assign head_y_o    = seg_y[0];
   assign body_x_o    = seg_x;
   assign body_y_o    = seg_y;
   assign cube_num_o  = cube_num_q;
   assign step_tick_o = step_tick_q;
   assign hit_wall_o  = hit_wall_q;
   assign hit_body_o  = hit_body_q;
   assign game_over_o = game_over_q;
endmodule
